// File: rtl/requant_pkg.sv
// Shared types and constants for the result requantizer: FSM states,
// int8 clamp limits and the 4x4 output tile geometry.
package requant_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_e;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  localparam int unsigned NUM_ROWS  = 4;
  localparam int unsigned NUM_COLS  = 4;
  localparam int unsigned NUM_ELEMS = NUM_ROWS * NUM_COLS;

endpackage

// File: rtl/requant_unit.sv
// Combinational requantizer: round-half-up arithmetic right shift of one
// accumulator, then int8 saturation. RESULT_REQUANT_RELU_EN clamps negatives to 0.
module requant_unit
  import requant_pkg::*;
#(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic [ACC_W-1:0]   x,
  input  logic [SHIFT_W-1:0] s,
  output logic [OUT_W-1:0]   q_c,
  output logic               sat_c
);

  localparam int unsigned EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] R_MAX = EXT_W'(INT8_MAX);
  localparam logic signed [EXT_W-1:0] R_MIN = EXT_W'(INT8_MIN);

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] bias;
  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] r;

  // One guard bit keeps x + rounding bias from wrapping near the positive limit.
  always_comb begin
    ext   = {x[ACC_W-1], x};
    bias  = '0;
    if (s != '0) begin
      bias = EXT_W'(1) << (s - SHIFT_W'(1));
    end
    sum   = ext + bias;
    r     = sum >>> s;
    q_c   = r[OUT_W-1:0];
    sat_c = 1'b0;
    if (r > R_MAX) begin
      q_c   = OUT_W'(INT8_MAX);
      sat_c = 1'b1;
    end else if (r < R_MIN) begin
      q_c   = OUT_W'(INT8_MIN);
      sat_c = 1'b1;
    end
`ifdef RESULT_REQUANT_RELU_EN
    if (r[EXT_W-1]) begin
      q_c   = '0;
      sat_c = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/result_requantizer.sv
// Requantizes a 16-accumulator result frame to int8 and replays it as four
// 32-bit row words. Optional ReLU clamp via RESULT_REQUANT_RELU_EN.
module result_requantizer
  import requant_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 2 * NUM_ROWS,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned ROWS      = NUM_ROWS,
  parameter int unsigned SHIFT_W   = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2*ACC_W-1:0]               in_data,
  input  logic [SHIFT_W-1:0]               shift_amt,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_COLS*OUT_W-1:0]        out_data,
  output logic [$clog2(ROWS)-1:0]          out_row,
  output logic [$clog2(2*NUM_WORDS+1)-1:0] sat_count,
  output logic                             frame_done
);

  localparam int unsigned NUM_E  = 2 * NUM_WORDS;
  localparam int unsigned WCNT_W = $clog2(NUM_WORDS);
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned SAT_W  = $clog2(NUM_E + 1);
  localparam int unsigned ROW_DW = NUM_COLS * OUT_W;

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [SAT_W-1:0]  SAT_MAX   = SAT_W'(NUM_E);

  state_e                      state_q, state_d;
  logic [WCNT_W-1:0]           word_cnt_q, word_cnt_d;
  logic [ROW_W-1:0]            row_cnt_q, row_cnt_d;
  logic [SHIFT_W-1:0]          shift_q;
  logic [SHIFT_W-1:0]          shift_eff;
  logic [NUM_E-1:0][OUT_W-1:0] elem_q;
  logic [ROWS-1:0][ROW_DW-1:0] row_word;
  logic [OUT_W-1:0]            q_hi, q_lo;
  logic                        sat_hi, sat_lo;
  logic [SAT_W-1:0]            sat_inc, sat_sum;
  logic                        in_acc;
  logic                        done_d;

  // Word 0 uses the live shift amount; later words use the value latched with it.
  assign shift_eff = (word_cnt_q == '0) ? shift_amt : shift_q;

  requant_unit #(
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT_W(SHIFT_W)
  ) u_requant_hi (
    .x    (in_data[2*ACC_W-1:ACC_W]),
    .s    (shift_eff),
    .q_c  (q_hi),
    .sat_c(sat_hi)
  );

  requant_unit #(
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT_W(SHIFT_W)
  ) u_requant_lo (
    .x    (in_data[ACC_W-1:0]),
    .s    (shift_eff),
    .q_c  (q_lo),
    .sat_c(sat_lo)
  );

  // Row word packing: column 0 in the most significant byte.
  always_comb begin
    row_word = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        row_word[r][(NUM_COLS-1-c)*OUT_W +: OUT_W] = elem_q[r*NUM_COLS+c];
      end
    end
  end

  // Saturation tally restarts with word 0 and sticks at the per-frame maximum.
  always_comb begin
    sat_inc = SAT_W'(sat_hi) + SAT_W'(sat_lo);
    sat_sum = ((word_cnt_q == '0) ? '0 : sat_count) + sat_inc;
    if (sat_sum > SAT_MAX) begin
      sat_sum = SAT_MAX;
    end
  end

  // Next-state logic; flush overrides both handshakes.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;
    in_acc     = 1'b0;
    done_d     = 1'b0;
    if (flush) begin
      state_d    = COLLECT;
      word_cnt_d = '0;
      row_cnt_d  = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_valid && in_ready) begin
            in_acc = 1'b1;
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d = '0;
              row_cnt_d  = '0;
              state_d    = OUTPUT;
            end else begin
              word_cnt_d = word_cnt_q + WCNT_W'(1);
            end
          end
        end
        OUTPUT: begin
          if (out_valid && out_ready) begin
            if (row_cnt_q == LAST_ROW) begin
              row_cnt_d = '0;
              done_d    = 1'b1;
              state_d   = COLLECT;
            end else begin
              row_cnt_d = row_cnt_q + ROW_W'(1);
            end
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= COLLECT;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      shift_q    <= '0;
      elem_q     <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      sat_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      in_ready   <= (state_d == COLLECT);
      out_valid  <= (state_d == OUTPUT);
      frame_done <= done_d;
      // Reloading the same row while stalled keeps out_data stable.
      if (state_d == OUTPUT) begin
        out_data <= row_word[row_cnt_d];
        out_row  <= row_cnt_d;
      end
      if (in_acc) begin
        elem_q[{word_cnt_q, 1'b0}] <= q_hi;
        elem_q[{word_cnt_q, 1'b1}] <= q_lo;
        if (word_cnt_q == '0) begin
          shift_q <= shift_amt;
        end
      end
      if (flush) begin
        sat_count <= '0;
      end else if (in_acc) begin
        sat_count <= sat_sum;
      end
    end
  end

endmodule

// File: tb/tb_result_requantizer.sv
// Directed bench for result_requantizer: identity, rounding, saturation,
// backpressure, flush and asynchronous reset, with hand-computed rows.
module tb_result_requantizer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [4:0]  shift_amt;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_row;
  logic [4:0]  sat_count;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  logic [31:0] vec     [16];
  logic [31:0] exp_row [4];

  always #5 clk = ~clk;

  result_requantizer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .shift_amt (shift_amt),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .sat_count (sat_count),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send_word(input logic [31:0] hi, input logic [31:0] lo);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = {hi, lo};
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_frame(input int nwords, input logic change_shift);
    for (int k = 0; k < nwords; k++) begin
      send_word(vec[2*k], vec[2*k+1]);
      if (change_shift && k == 0) shift_amt = 5'd0;
    end
  endtask

  task automatic recv_rows(input int first, input logic strict);
    int waits;
    waits     = 0;
    out_ready = 1'b1;
    for (int r = first; r < 4; r++) begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      waits += n;
      check($sformatf("row%0d_valid", r), 32'(out_valid), 32'd1);
      check($sformatf("row%0d_index", r), 32'(out_row), 32'(r));
      check($sformatf("row%0d_data", r), out_data, exp_row[r]);
      @(negedge clk);
    end
    if (strict) check("row_latency_waits", 32'(waits), 32'd0);
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    check("in_ready_after_frame", 32'(in_ready), 32'd1);
    check("out_valid_after_frame", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("frame_done_single", 32'(frame_done), 32'd0);
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 16; i++) vec[i] = 32'd0;
    for (int r = 0; r < 4; r++) exp_row[r] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    shift_amt = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #22;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_row", 32'(out_row), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_rise", 32'(in_ready), 32'd1);

    // Identity, with out_ready high during collection (must be ignored).
    out_ready = 1'b1;
    shift_amt = 5'd0;
    for (int i = 0; i < 16; i++) vec[i] = 32'(i);
    exp_row[0] = 32'h00010203;
    exp_row[1] = 32'h04050607;
    exp_row[2] = 32'h08090A0B;
    exp_row[3] = 32'h0C0D0E0F;
    @(negedge clk);
    check("collect_out_valid", 32'(out_valid), 32'd0);
    send_frame(8, 1'b0);
    recv_rows(0, 1'b1);
    check("identity_sat", 32'(sat_count), 32'd0);

    // Rounding at s=4; shift_amt drops to 0 after word 0 to prove it was latched.
    clear_vec();
    shift_amt = 5'd4;
    vec[0] = 32'd24;
    vec[1] = 32'd23;
    vec[2] = 32'hFFFF_FFE8;
    vec[3] = 32'hFFFF_FFE7;
    vec[4] = 32'd40;
`ifdef RESULT_REQUANT_RELU_EN
    exp_row[0] = 32'h02010000;
`else
    exp_row[0] = 32'h0201FFFE;
`endif
    exp_row[1] = 32'h03000000;
    send_frame(8, 1'b1);
    recv_rows(0, 1'b1);
    check("round_sat", 32'(sat_count), 32'd0);

    // Largest accumulator at s=0 saturates without wrapping.
    clear_vec();
    shift_amt  = 5'd0;
    vec[0]     = 32'h7FFF_FFFF;
    exp_row[0] = 32'h7F000000;
    send_frame(8, 1'b0);
    recv_rows(0, 1'b1);
    check("maxpos_sat", 32'(sat_count), 32'd1);

    // s=31: rounding bias must not overflow the extended sum.
    clear_vec();
    shift_amt = 5'd31;
    vec[0]    = 32'h7FFF_FFFF;
    vec[1]    = 32'h8000_0000;
    vec[2]    = 32'hC000_0000;
`ifdef RESULT_REQUANT_RELU_EN
    exp_row[0] = 32'h01000000;
`else
    exp_row[0] = 32'h01FF0000;
`endif
    send_frame(8, 1'b0);
    recv_rows(0, 1'b1);
    check("shift31_sat", 32'(sat_count), 32'd0);

    // Saturation in both directions on every element.
    shift_amt = 5'd0;
    for (int i = 0; i < 16; i++) vec[i] = (i % 2 == 0) ? 32'd1000 : 32'hFFFF_FC18;
    for (int r = 0; r < 4; r++) begin
`ifdef RESULT_REQUANT_RELU_EN
      exp_row[r] = 32'h7F007F00;
`else
      exp_row[r] = 32'h7F807F80;
`endif
    end
    send_frame(8, 1'b0);
    recv_rows(0, 1'b1);
`ifdef RESULT_REQUANT_RELU_EN
    check("sat_all_count", 32'(sat_count), 32'd8);
`else
    check("sat_all_count", 32'(sat_count), 32'd16);
`endif

    // Mixed sign small frame: -50 and 300.
    clear_vec();
    vec[0] = 32'hFFFF_FFCE;
    vec[1] = 32'd300;
`ifdef RESULT_REQUANT_RELU_EN
    exp_row[0] = 32'h007F0000;
`else
    exp_row[0] = 32'hCE7F0000;
`endif
    send_frame(8, 1'b0);
    recv_rows(0, 1'b1);
    check("relu_sat", 32'(sat_count), 32'd1);

    // Backpressure on row 1 with stray input words offered.
    for (int i = 0; i < 16; i++) vec[i] = 32'(16 + i);
    exp_row[0] = 32'h10111213;
    exp_row[1] = 32'h14151617;
    exp_row[2] = 32'h18191A1B;
    exp_row[3] = 32'h1C1D1E1F;
    send_frame(8, 1'b0);
    check("bp_row0_data", out_data, exp_row[0]);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'hDEAD_BEEF_0BAD_F00D;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_out_row", 32'(out_row), 32'd1);
      check("bp_out_data", out_data, exp_row[1]);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    recv_rows(1, 1'b0);

    // Flush after word 5 of a saturating frame, with a competing input word.
    for (int i = 0; i < 16; i++) vec[i] = 32'd1000;
    send_frame(6, 1'b0);
    check("pre_flush_sat", 32'(sat_count), 32'd12);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = {32'd1000, 32'd1000};
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_sat", 32'(sat_count), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_no_done", 32'(frame_done), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 16; i++) vec[i] = 32'(32 + i);
    exp_row[0] = 32'h20212223;
    exp_row[1] = 32'h24252627;
    exp_row[2] = 32'h28292A2B;
    exp_row[3] = 32'h2C2D2E2F;
    send_frame(8, 1'b0);
    recv_rows(0, 1'b1);
    check("post_flush_sat", 32'(sat_count), 32'd0);

    // Asynchronous reset while a row is waiting.
    out_ready = 1'b0;
    send_frame(8, 1'b0);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd0);
    check("async_out_data", out_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", 32'(in_ready), 32'd1);
    check("post_reset_out_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
